// File: rtl/sys_drain_if.sv
// Bus bundle for sys_drain: skewed column sums in, aligned result rows out.
// Optional macro SYS_DRAIN_ROWIDX_EN adds the 8-bit out_idx row index.
interface sys_drain_if #(
    parameter int N     = 4,
    parameter int SUM_W = 9,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N*SUM_W-1:0] in_sum;
    logic [N-1:0]       in_valid;
    logic               out_valid;
    logic               out_ready;
    logic [N*SUM_W-1:0] out_row;
    logic [CW-1:0]      out_count;
    logic               err_skew;
    logic               err_ovf;
`ifdef SYS_DRAIN_ROWIDX_EN
    logic [7:0]         out_idx;
`endif

    // Producer of column sums and consumer of rows.
    modport master (
        output in_sum, in_valid, out_ready,
        input  out_valid, out_row, out_count, err_skew, err_ovf
`ifdef SYS_DRAIN_ROWIDX_EN
        , input out_idx
`endif
    );

    // The drain itself.
    modport slave (
        input  in_sum, in_valid, out_ready,
        output out_valid, out_row, out_count, err_skew, err_ovf
`ifdef SYS_DRAIN_ROWIDX_EN
        , output out_idx
`endif
    );
endinterface

// File: rtl/sys_drain.sv
// Systolic array output drain: deskews the bottom-row column sums, checks
// that each row lines up, and queues complete rows in a small FIFO.
// Optional macro SYS_DRAIN_ROWIDX_EN tags every queued row with an 8-bit index.
module sys_drain #(
    parameter int WIDTH = 3,
    parameter int N     = 4,
    parameter int SUM_W = 3 * WIDTH,
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    sys_drain_if.slave bus
);
    localparam int NS = N - 1;             // deskew stages of column 0
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef logic [N*SUM_W-1:0] row_t;

    if (SUM_W < 2 * WIDTH) begin : g_bad_sum_w
        $error("sys_drain: SUM_W narrower than a product");
    end

    row_t           stg_sum_q [NS];
    row_t           stg_sum_d [NS];
    logic [N-1:0]   stg_vld_q [NS];
    logic [N-1:0]   stg_vld_d [NS];

    row_t           al_sum;
    logic [N-1:0]   al_vld;
    logic           row_full, row_part, pop, push;

    row_t           mem_q [DEPTH];
    row_t           mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    row_t           hold_q, hold_d;
    logic           skew_q, skew_d, ovf_q, ovf_d;

    // Deskew shift: column j enters at stage j and shifts to the last stage,
    // so it sees NS-j registers; column N-1 bypasses the chain entirely.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            stg_sum_d[s] = '0;
            stg_vld_d[s] = '0;
        end
        stg_sum_d[0][0 +: SUM_W] = bus.in_sum[0 +: SUM_W];
        stg_vld_d[0][0]          = bus.in_valid[0];
        for (int s = 1; s < NS; s++) begin
            for (int j = 0; j < N; j++) begin
                if (j < s) begin
                    stg_sum_d[s][j*SUM_W +: SUM_W] = stg_sum_q[s-1][j*SUM_W +: SUM_W];
                    stg_vld_d[s][j]                = stg_vld_q[s-1][j];
                end else if (j == s) begin
                    stg_sum_d[s][j*SUM_W +: SUM_W] = bus.in_sum[j*SUM_W +: SUM_W];
                    stg_vld_d[s][j]                = bus.in_valid[j];
                end
            end
        end
    end

    // Deskew registers; reset discards any partially captured row.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            if (reset) begin
                stg_sum_q[s] <= '0;
                stg_vld_q[s] <= '0;
            end else begin
                stg_sum_q[s] <= stg_sum_d[s];
                stg_vld_q[s] <= stg_vld_d[s];
            end
        end
    end

    // Aligned row view: last deskew stage plus the undelayed last column.
    always_comb begin
        al_sum = stg_sum_q[NS-1];
        al_vld = stg_vld_q[NS-1];
        al_sum[(N-1)*SUM_W +: SUM_W] = bus.in_sum[(N-1)*SUM_W +: SUM_W];
        al_vld[N-1]                  = bus.in_valid[N-1];
    end

    // Row check and FIFO control; a full FIFO still takes a row when it pops.
    always_comb begin
        row_full = &al_vld;
        row_part = (|al_vld) & ~row_full;
        pop      = (count_q != '0) & bus.out_ready;
        push     = row_full & ((count_q < CW'(DEPTH)) | pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;
        skew_d   = skew_q | row_part;
        ovf_d    = ovf_q | (row_full & ~push);
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = al_sum;
    end

    // FIFO bookkeeping and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            skew_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            skew_q   <= skew_d;
            ovf_q    <= ovf_d;
        end
    end

    // Row storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_row   = bus.out_valid ? mem_q[rd_ptr_q] : hold_q;
    assign bus.out_count = count_q;
    assign bus.err_skew  = skew_q;
    assign bus.err_ovf   = ovf_q;

`ifdef SYS_DRAIN_ROWIDX_EN
    logic [7:0] idx_q, idx_d, idx_hold_q, idx_hold_d;
    logic [7:0] idx_mem_q [DEPTH];
    logic [7:0] idx_mem_d [DEPTH];

    // Row index: advances only on accepted pushes and travels with the row.
    always_comb begin
        idx_d      = push ? idx_q + 8'd1 : idx_q;
        idx_hold_d = pop ? idx_mem_q[rd_ptr_q] : idx_hold_q;
        idx_mem_d  = idx_mem_q;
        if (push) idx_mem_d[wr_ptr_q] = idx_q;
    end

    // Index counter and head-index hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            idx_hold_q <= '0;
        end else begin
            idx_q      <= idx_d;
            idx_hold_q <= idx_hold_d;
        end
    end

    // Index storage alongside the row storage.
    always_ff @(posedge clk) begin
        idx_mem_q <= idx_mem_d;
    end

    assign bus.out_idx = bus.out_valid ? idx_mem_q[rd_ptr_q] : idx_hold_q;
`endif
endmodule

// File: tb/tb_sys_drain.sv
// Bench for sys_drain: a cycle-keyed alignment model plus a queue FIFO model,
// compared every cycle, with directed rows and literal spot checks.
module tb_sys_drain;
    localparam int N = 4, WIDTH = 3, SUM_W = 9, DEPTH = 4;
    typedef logic [N*SUM_W-1:0] row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sys_drain_if #(.N(N), .SUM_W(SUM_W), .DEPTH(DEPTH)) bus();
    sys_drain #(.WIDTH(WIDTH), .N(N), .SUM_W(SUM_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    bit garbage = 1'b1;
    bit live = 1'b0;
    bit stop = 1'b0;

    // Stimulus table: per cycle, which columns are valid and their sums.
    logic [N-1:0] dv [int];
    row_t         ds [int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One matrix row: column j carries base+j at cycle t+j (late_col one later).
    task automatic add_row(input int t, input int base, input int late_col);
        for (int j = 0; j < N; j++) begin
            int c;
            logic [N-1:0] v;
            row_t s;
            c = t + j + ((j == late_col) ? 1 : 0);
            v = dv.exists(c) ? dv[c] : '0;
            s = ds.exists(c) ? ds[c] : '0;
            v[j] = 1'b1;
            s[j*SUM_W +: SUM_W] = SUM_W'(base + j);
            dv[c] = v;
            ds[c] = s;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // Input driver, applied shortly after each edge for the cycle now starting.
    always @(posedge clk) begin
        #2;
        if (garbage) begin
            bus.in_valid = N'($urandom);
            bus.in_sum   = {$urandom, $urandom};
        end else if (dv.exists(cyc)) begin
            bus.in_valid = dv[cyc];
            bus.in_sum   = ds[cyc];
        end else begin
            bus.in_valid = '0;
            bus.in_sum   = {$urandom, $urandom};
        end
    end

    // Model: a column-j sample at cycle c belongs to the aligned row of
    // cycle c+N-1-j; a row is pushed only when every column lands together.
    logic [N-1:0] mv [int];
    row_t         ms [int];
    row_t         q [$];
    logic [7:0]   qi [$];
    row_t         last;
    logic [7:0]   lidx, nidx;
    bit           eskew, eovf;

    always @(posedge clk) begin
        if (reset) begin
            live = 1'b1;
            mv.delete(); ms.delete(); q.delete(); qi.delete();
            last = '0; lidx = '0; nidx = '0; eskew = 1'b0; eovf = 1'b0;
        end else if (live) begin
            logic [N-1:0] v;
            row_t r;
            bit pop;
            for (int j = 0; j < N; j++) begin
                if (bus.in_valid[j]) begin
                    int k;
                    logic [N-1:0] tv;
                    row_t ts;
                    k  = cyc + N - 1 - j;
                    tv = mv.exists(k) ? mv[k] : '0;
                    ts = ms.exists(k) ? ms[k] : '0;
                    tv[j] = 1'b1;
                    ts[j*SUM_W +: SUM_W] = bus.in_sum[j*SUM_W +: SUM_W];
                    mv[k] = tv;
                    ms[k] = ts;
                end
            end
            v = mv.exists(cyc) ? mv[cyc] : '0;
            r = ms.exists(cyc) ? ms[cyc] : '0;
            mv.delete(cyc); ms.delete(cyc);
            pop = (q.size() > 0) && bus.out_ready;
            if (pop) begin
                last = q.pop_front();
                lidx = qi.pop_front();
            end
            if (v == '1) begin
                if (q.size() < DEPTH) begin
                    q.push_back(r);
                    qi.push_back(nidx);
                    nidx++;
                end else eovf = 1'b1;
            end else if (v != '0) eskew = 1'b1;
        end
        cyc++;
    end

    // Compare every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (live && !stop) begin
            chk("out_valid", bus.out_valid, q.size() > 0);
            chk("out_row",   bus.out_row, (q.size() > 0) ? q[0] : last);
            chk("out_count", bus.out_count, q.size());
            chk("err_skew",  bus.err_skew, eskew);
            chk("err_ovf",   bus.err_ovf, eovf);
`ifdef SYS_DRAIN_ROWIDX_EN
            chk("out_idx",   bus.out_idx, (q.size() > 0) ? qi[0] : lidx);
`endif
        end
    end

    initial begin
        int t;
        bus.in_valid  = '0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        garbage = 1'b1;
        step(2);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_row",   bus.out_row, '0);
        chk("rst_count", bus.out_count, 0);
        chk("rst_flags", {bus.err_skew, bus.err_ovf}, 2'b00);
        reset = 1'b0;
        garbage = 1'b0;

        // Single row, four cycles to the output, gone after one pop.
        bus.out_ready = 1'b1;
        t = cyc + 1;
        add_row(t, 12, -1);
        wait_until(t + 4);
        chk("single_valid", bus.out_valid, 1'b1);
        chk("single_row", bus.out_row, {9'd15, 9'd14, 9'd13, 9'd12});
        step(1);
        chk("single_gone", bus.out_valid, 1'b0);

        // Six back-to-back rows into a stalled FIFO: two dropped.
        bus.out_ready = 1'b0;
        t = cyc + 1;
        for (int r = 0; r < 6; r++) add_row(t + r, 16 * (r + 1), -1);
        wait_until(t + 10);
        chk("ovf_count", bus.out_count, 4);
        chk("ovf_flag", bus.err_ovf, 1'b1);
        chk("ovf_head", bus.out_row, {9'd19, 9'd18, 9'd17, 9'd16});
        bus.out_ready = 1'b1;
        step(4);
        chk("ovf_drained", bus.out_count, 0);
        chk("ovf_noskew", bus.err_skew, 1'b0);

        // Column 2 one cycle late: skew error, nothing queued.
        t = cyc + 1;
        add_row(t, 40, 2);
        wait_until(t + 6);
        chk("skew_flag", bus.err_skew, 1'b1);
        chk("skew_count", bus.out_count, 0);
        t = cyc + 1;
        add_row(t, 50, -1);
        wait_until(t + 4);
        chk("skew_next", bus.out_row, {9'd53, 9'd52, 9'd51, 9'd50});

        // Full FIFO popping while a fifth row lands: accepted, no overflow.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        t = cyc + 1;
        for (int r = 0; r < 5; r++) add_row(t + r, 60 + 4 * r, -1);
        wait_until(t + 7);
        chk("full_count", bus.out_count, 4);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        chk("full_count2", bus.out_count, 4);
        chk("full_noovf", bus.err_ovf, 1'b0);
        chk("full_head", bus.out_row, {9'd67, 9'd66, 9'd65, 9'd64});
        bus.out_ready = 1'b1;
        step(6);
        chk("full_drained", bus.out_count, 0);

        // Reset in the middle of a row: nothing ever emerges.
        t = cyc + 1;
        add_row(t, 100, -1);
        wait_until(t + 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(8);
        chk("inflight_count", bus.out_count, 0);
        chk("inflight_valid", bus.out_valid, 1'b0);
        t = cyc + 1;
        add_row(t, 200, -1);
        wait_until(t + 4);
        chk("post_rst_row", bus.out_row, {9'd203, 9'd202, 9'd201, 9'd200});
`ifdef SYS_DRAIN_ROWIDX_EN
        chk("post_rst_idx", bus.out_idx, 8'd0);
`endif
        step(3);
        stop = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sys_drain.md
Name: sys_drain

Overview:
- Output drain for the systolic array; the reader for the PE sum chain.
- Sits below the bottom PE row and captures each column's out_sum. Column j's result arrives j cycles after column 0.
- Removes the skew, packs one aligned result row per matrix row, and buffers rows in a small FIFO for a valid/ready consumer.
- Flags protocol errors: misaligned column valids and FIFO overflow.

Parameters:
- WIDTH, 3, operand width of the PE array (matches proc_elem WIDTH).
- N, 4, number of array columns drained.
- SUM_W, 3*WIDTH, width of one column partial sum (9 at default).
- DEPTH, 4, output FIFO depth in rows; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_sum  in  N*SUM_W  bottom-row out_sum bus; column j at bits [j*SUM_W +: SUM_W].
- in_valid  in  N  per-column sample valid; bit j qualifies column j.
- out_valid  out  1  FIFO head row available.
- out_ready  in  1  consumer accepts the head row this cycle.
- out_row  out  N*SUM_W  aligned result row, same column packing as in_sum.
- out_count  out  clog2(DEPTH)+1  rows currently stored.
- err_skew  out  1  sticky: aligned valid bits disagreed.
- err_ovf  out  1  sticky: aligned row dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - Clears all deskew registers, FIFO pointers, out_count, err_skew and err_ovf.
  - Drives out_valid=0 and out_row=0.
  - Takes precedence over every other event, including a mid-row capture. Partial rows are discarded.
- Deskew:
  - Column j passes through N-1-j register stages, sum and valid bit together.
  - Column N-1 has zero stages.
  - At stage output, all columns of one matrix row line up in the same cycle.
- Alignment check, evaluated on the deskewed valid vector v each cycle:
  - v all ones: the row is complete; push request.
  - v all zeros: idle.
  - Any other value: set err_skew; no push; partial data discarded.
- Latency:
  - in_valid[0] sampled at cycle t, and column j at t+j, gives a push at the edge ending cycle t+N-1.
  - out_valid=1 from cycle t+N when the FIFO was empty (N cycles first-row latency).
  - There is no combinational path from in_* to out_*.
- FIFO:
  - A pop occurs when out_valid & out_ready at the rising edge. out_row presents the head row and holds while out_valid=1 and out_ready=0.
  - A push is accepted when out_count<DEPTH, or when out_count==DEPTH and a pop occurs in the same cycle.
  - A push refused because the FIFO is full sets err_ovf and drops the row. FIFO contents are unchanged.
  - Simultaneous push and pop: out_count unchanged; ordering preserved.
  - Empty: out_valid=0 and out_row holds its last popped value (0 after reset). out_ready is ignored.
  - Read and write pointers wrap modulo DEPTH. Full and empty are distinguished by out_count.
- Sticky flags stay set until reset.
- Sums pass through unmodified at full SUM_W; no truncation.
- Back-to-back rows (one new row per cycle per column) are sustained with no bubbles while out_ready=1.

Optional Feature:
- Macro SYS_DRAIN_ROWIDX_EN.
- Defined:
  - Adds output port out_idx, 8 bits: the index of the head row.
  - A counter increments per accepted push, wraps from 255 to 0, and is stored alongside each FIFO entry.
  - Reset clears the counter to 0.
  - Dropped (overflow) rows do not consume an index.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (N=4, WIDTH=3, SUM_W=9, DEPTH=4):
- Reset held 2 cycles with garbage on in_* → out_valid=0, out_row=0, out_count=0, both err flags 0.
- Single row: column j gets sum 12+j with in_valid bit j at cycle t+j, out_ready=1 → out_valid=1 at t+4 with out_row = {15,14,13,12} for columns 3..0, for exactly one cycle.
- 6 back-to-back skewed rows, out_ready=0 → out_count reaches 4 and rows 5–6 are dropped with err_ovf=1. Then out_ready=1 pops rows 1–4 in order and out_count returns to 0.
- Misaligned valid: column 2 valid one cycle late for a row → err_skew=1, no push, out_count unchanged. A following correct row still drains correctly.
- FIFO full with out_ready=1 while a new row arrives → push accepted, err_ovf stays 0, out_count stays 4, order preserved.
- Reset asserted at t+2 of an in-flight row → no row is ever emitted, out_count=0. With SYS_DRAIN_ROWIDX_EN defined, the next row carries out_idx=0.
